// File: rtl/bomb_slot_pool_if.sv
// Player-to-bomb-pool bundle: control inputs from the player side and the
// slot state/position buses read by the renderers.
interface bomb_slot_pool_if #(
    parameter int NUM_SLOTS = 3
);
    logic                     round_reset;
    logic                     OneSecPulse;
    logic                     drop_key;
    logic                     inc_bomb;
    logic [10:0]              player_topLeftX;
    logic [10:0]              player_topLeftY;
    logic [NUM_SLOTS-1:0]     chain_hit;
    logic [NUM_SLOTS-1:0]     slot_armed;
    logic [NUM_SLOTS-1:0]     slot_blasting;
    logic [11*NUM_SLOTS-1:0]  slot_x;
    logic [11*NUM_SLOTS-1:0]  slot_y;
    logic [3:0]               bombs_left;
    logic                     drop_ack;
    logic                     drop_reject;
    logic                     blast;
    logic                     explosion;

    modport master (
        output round_reset, OneSecPulse, drop_key, inc_bomb,
               player_topLeftX, player_topLeftY, chain_hit,
        input  slot_armed, slot_blasting, slot_x, slot_y, bombs_left,
               drop_ack, drop_reject, blast, explosion
    );

    modport slave (
        input  round_reset, OneSecPulse, drop_key, inc_bomb,
               player_topLeftX, player_topLeftY, chain_hit,
        output slot_armed, slot_blasting, slot_x, slot_y, bombs_left,
               drop_ack, drop_reject, blast, explosion
    );
endinterface

// File: rtl/bomb_slot_pool.sv
// Per-player bomb pool: NUM_SLOTS independent fuse/blast slots, drop-key edge
// detection with tile-occupancy rejection, capacity pickups and chain detonation.
module bomb_slot_pool #(
    parameter int NUM_SLOTS     = 3,
    parameter int START_BOMBS   = 2,
    parameter int MAX_BOMBS     = 3,
    parameter int FUSE_SECONDS  = 3,
    parameter int BLAST_SECONDS = 1,
    parameter int GRID_SHIFT    = 5
) (
    input  logic              clk,
    input  logic              resetN,
    bomb_slot_pool_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2
    } slot_state_e;

    // Rounding to the nearest tile commutes with 11-bit truncation, so the
    // whole snap can stay 11 bits wide.
    localparam logic [10:0] HALF_TILE = 11'(1 << (GRID_SHIFT - 1));
    localparam logic [10:0] TILE_MASK = ~11'((1 << GRID_SHIFT) - 1);

    logic [10:0]             snap_x, snap_y;
    logic [NUM_SLOTS-1:0]    idle_w, armed_w, blasting_w, occupied_w, entering_w;
    logic [NUM_SLOTS-1:0]    alloc;
    logic [11*NUM_SLOTS-1:0] slot_x_w, slot_y_w;
    logic [3:0]              armed_cnt, bombs_left_w;
    logic                    drop_edge, accept, found;

    logic       key_q, key_d;
    logic [3:0] cap_q, cap_d;
    logic       ack_q, ack_d;
    logic       rej_q, rej_d;
    logic       blast_q, blast_d;

    assign snap_x = (bus.player_topLeftX + HALF_TILE) & TILE_MASK;
    assign snap_y = (bus.player_topLeftY + HALF_TILE) & TILE_MASK;

    always_comb begin
        armed_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            armed_cnt = armed_cnt + 4'(armed_w[i]);
        end
    end

    assign bombs_left_w = cap_q - armed_cnt;

    // Decisions use registered slot state only, so a slot that is leaving
    // ARMED or BLAST in this cycle is still treated as busy.
    always_comb begin
        drop_edge = bus.drop_key & ~key_q;
        accept    = drop_edge && (bombs_left_w != 4'd0) && (|idle_w) && !(|occupied_w);
        alloc     = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idle_w[i] && !found) begin
                alloc[i] = accept;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        key_d   = bus.drop_key;
        cap_d   = cap_q;
        ack_d   = accept;
        rej_d   = drop_edge & ~accept;
        blast_d = |entering_w;
        if (bus.inc_bomb && (cap_q < 4'(MAX_BOMBS))) begin
            cap_d = cap_q + 4'd1;
        end
        if (bus.round_reset) begin
            key_d   = 1'b0;
            cap_d   = 4'(START_BOMBS);
            ack_d   = 1'b0;
            rej_d   = 1'b0;
            blast_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_q   <= 1'b0;
            cap_q   <= 4'(START_BOMBS);
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            blast_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            cap_q   <= cap_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            blast_q <= blast_d;
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        slot_state_e state_q, state_d;
        logic [3:0]  cnt_q, cnt_d;
        logic [10:0] x_q, x_d, y_q, y_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            x_d     = x_q;
            y_d     = y_q;
            case (state_q)
                S_IDLE: begin
                    if (alloc[gi]) begin
                        state_d = S_ARMED;
                        cnt_d   = 4'(FUSE_SECONDS);
                        x_d     = snap_x;
                        y_d     = snap_y;
                    end
                end
                S_ARMED: begin
                    if (bus.chain_hit[gi] || (bus.OneSecPulse && cnt_q == 4'd1)) begin
                        state_d = S_BLAST;
                        cnt_d   = 4'(BLAST_SECONDS);
                    end else if (bus.OneSecPulse) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_BLAST: begin
                    if (bus.OneSecPulse) begin
                        if (cnt_q == 4'd1) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                            x_d     = 11'd0;
                            y_d     = 11'd0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (bus.round_reset) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                x_d     = 11'd0;
                y_d     = 11'd0;
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state_q <= S_IDLE;
                cnt_q   <= 4'd0;
                x_q     <= 11'd0;
                y_q     <= 11'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                x_q     <= x_d;
                y_q     <= y_d;
            end
        end

        assign idle_w[gi]     = (state_q == S_IDLE);
        assign armed_w[gi]    = (state_q == S_ARMED);
        assign blasting_w[gi] = (state_q == S_BLAST);
        assign entering_w[gi] = (state_q == S_ARMED) && (state_d == S_BLAST);
        assign occupied_w[gi] = (state_q != S_IDLE) && (x_q == snap_x) && (y_q == snap_y);
        assign slot_x_w[11*gi +: 11] = x_q;
        assign slot_y_w[11*gi +: 11] = y_q;
    end

    assign bus.slot_armed    = armed_w;
    assign bus.slot_blasting = blasting_w;
    assign bus.slot_x        = slot_x_w;
    assign bus.slot_y        = slot_y_w;
    assign bus.bombs_left    = bombs_left_w;
    assign bus.drop_ack      = ack_q;
    assign bus.drop_reject   = rej_q;
    assign bus.blast         = blast_q;
    assign bus.explosion     = |blasting_w;
endmodule
